// File: rtl/scurve_pkg.sv
// scurve_pkg: shared state encoding, widths, Data_out layout and 40 MHz timing
// defaults for the S-curve scan sequencer.
package scurve_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_BCID, ST_LOAD, ST_SETTLE, ST_TRIG,
    ST_WINDOW, ST_RAZ, ST_OUT, ST_NEXT, ST_DONE
  } scurve_state_e;

  localparam int DAC_WIDTH_DEF = 10;
  localparam int CNT_WIDTH_DEF = 16;

  // Data_out = {zero pad, Dac_code, hit_cnt}; the DAC field sits right above hit_cnt
  localparam int DOUT_WIDTH   = 32;
  localparam int DOUT_HIT_LSB = 0;

  // 40 MHz Clk, 25 ns per cycle
  localparam int SETTLE_CYCLES_DEF = 400;
  localparam int WINDOW_CYCLES_DEF = 8;
  localparam int RAZ_GAP_DEF       = 48;
  localparam int BCID_WAIT_DEF     = 48;
  localparam int TMR_WIDTH         = 16;

endpackage

// File: rtl/scurve_step_timer.sv
// scurve_step_timer: loadable down-counter; o_tc pulses for one cycle when the
// loaded count has run out, so a state loaded with N-1 on entry lasts N cycles.
module scurve_step_timer
  import scurve_pkg::*;
#(
  parameter int WIDTH = TMR_WIDTH
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_cnt;
  logic             r_armed;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= i_value;
      r_armed <= 1'b1;
    end else if (r_armed) begin
      if (r_cnt == '0) r_armed <= 1'b0;
      else             r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign o_tc = r_armed && (r_cnt == '0);

endmodule

// File: rtl/scurve_seq_ctrl.sv
// scurve_seq_ctrl: S-curve threshold scan sequencer (BCID reset, DAC load, settle,
// trigger/window/RAZ loop, one result word per step). Macro SCURVE_FORCE_RAZ_EN adds Force_raz.
//
// state  | meaning
// IDLE   | waiting for Start
// BCID   | Rst_cntb pulse, then BCID_WAIT cycles
// LOAD   | Dac_load pulse, wait for Dac_load_done
// SETTLE | SETTLE_CYCLES of threshold settling
// TRIG   | single Trig_en cycle
// WINDOW | WINDOW_CYCLES of Chn_trig sampling
// RAZ    | Raz_en pulse plus RAZ_GAP quiet cycles
// OUT    | result word held until Data_ready
// NEXT   | advance threshold or finish
// DONE   | Done pulse
module scurve_seq_ctrl
  import scurve_pkg::*;
#(
  parameter int DAC_WIDTH     = DAC_WIDTH_DEF,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int RAZ_GAP       = RAZ_GAP_DEF,
  parameter int BCID_WAIT     = BCID_WAIT_DEF
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic [DAC_WIDTH-1:0]  Dac_start,
  input  logic [DAC_WIDTH-1:0]  Dac_stop,
  input  logic [3:0]            Dac_step,
  input  logic [CNT_WIDTH-1:0]  Trig_num,
  input  logic                  Chn_trig,
  input  logic                  Dac_load_done,
  input  logic                  Data_ready,
  output logic [DAC_WIDTH-1:0]  Dac_code,
  output logic                  Dac_load,
  output logic                  Rst_cntb,
  output logic                  Trig_en,
  output logic                  Raz_en,
  output logic [DOUT_WIDTH-1:0] Data_out,
  output logic                  Data_valid,
  output logic                  Busy,
`ifdef SCURVE_FORCE_RAZ_EN
  output logic                  Force_raz,
`endif
  output logic                  Done
);

  scurve_state_e         r_state, w_state_nxt;
  logic [DAC_WIDTH-1:0]  r_dac_start, r_dac_stop, r_dac_code;
  logic [3:0]            r_step;
  logic [CNT_WIDTH-1:0]  r_trig_num, r_trig_cnt, r_hit_cnt;
  logic                  r_hit_seen;
  logic                  r_dac_load, r_rst_cntb, r_trig_en, r_raz_en;
  logic                  r_data_valid, r_busy, r_done;
  logic [DOUT_WIDTH-1:0] r_data_out;
`ifdef SCURVE_FORCE_RAZ_EN
  logic                  r_force_raz;
`endif

  logic                  w_tmr_load, w_tc, w_last;
  logic [TMR_WIDTH-1:0]  w_tmr_val;
  logic [3:0]            w_step_eff;
  logic [DAC_WIDTH:0]    w_next_sum;
  logic [DOUT_WIDTH-1:0] w_word;

  scurve_step_timer #(.WIDTH(TMR_WIDTH)) u_timer (
    .Clk     (Clk),
    .reset_n (reset_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_val),
    .o_tc    (w_tc)
  );

  // the extra MSB of w_next_sum catches wrap past the top DAC code
  assign w_step_eff = (r_step == 4'd0) ? 4'd1 : r_step;
  assign w_next_sum = {1'b0, r_dac_code} + {{(DAC_WIDTH-3){1'b0}}, w_step_eff};
  assign w_last     = w_next_sum[DAC_WIDTH] || (w_next_sum[DAC_WIDTH-1:0] > r_dac_stop)
                      || (r_dac_start > r_dac_stop);

  always_comb begin
    w_word = '0;
    w_word[DOUT_HIT_LSB +: CNT_WIDTH]             = r_hit_cnt;
    w_word[DOUT_HIT_LSB + CNT_WIDTH +: DAC_WIDTH] = r_dac_code;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    unique case (r_state)
      ST_IDLE: if (Start && !Stop && (Trig_num != '0)) begin
        w_state_nxt = ST_BCID;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_WIDTH'(BCID_WAIT);
      end
      ST_BCID:   if (w_tc) w_state_nxt = ST_LOAD;
      ST_LOAD: if (Dac_load_done) begin
        w_state_nxt = ST_SETTLE;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_WIDTH'(SETTLE_CYCLES - 1);
      end
      ST_SETTLE: if (w_tc) w_state_nxt = ST_TRIG;
      ST_TRIG: begin
        w_state_nxt = ST_WINDOW;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_WIDTH'(WINDOW_CYCLES - 1);
      end
      ST_WINDOW: if (w_tc) begin
        w_state_nxt = ST_RAZ;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_WIDTH'(RAZ_GAP);
      end
      ST_RAZ: if (w_tc) w_state_nxt = (r_trig_cnt == r_trig_num) ? ST_OUT : ST_TRIG;
      ST_OUT:    if (Data_ready) w_state_nxt = ST_NEXT;
      ST_NEXT:   w_state_nxt = w_last ? ST_DONE : ST_LOAD;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && Stop) begin
      w_state_nxt = ST_IDLE;
      w_tmr_load  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_dac_start  <= '0;
      r_dac_stop   <= '0;
      r_dac_code   <= '0;
      r_step       <= '0;
      r_trig_num   <= '0;
      r_trig_cnt   <= '0;
      r_hit_cnt    <= '0;
      r_hit_seen   <= 1'b0;
      r_dac_load   <= 1'b0;
      r_rst_cntb   <= 1'b0;
      r_trig_en    <= 1'b0;
      r_raz_en     <= 1'b0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_data_out   <= '0;
`ifdef SCURVE_FORCE_RAZ_EN
      r_force_raz  <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      // outputs are registered copies of the state being entered
      r_rst_cntb   <= (w_state_nxt == ST_BCID) && (r_state != ST_BCID);
      r_dac_load   <= (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
      r_trig_en    <= (w_state_nxt == ST_TRIG);
      r_raz_en     <= (w_state_nxt == ST_RAZ) && (r_state != ST_RAZ);
      r_data_valid <= (w_state_nxt == ST_OUT);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
`ifdef SCURVE_FORCE_RAZ_EN
      r_force_raz  <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SETTLE);
`endif
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_BCID)) begin
        r_dac_start <= Dac_start;
        r_dac_stop  <= Dac_stop;
        r_step      <= Dac_step;
        r_trig_num  <= Trig_num;
        r_dac_code  <= Dac_start;
      end
      if ((r_state == ST_LOAD) && (w_state_nxt == ST_SETTLE)) begin
        r_trig_cnt <= '0;
        r_hit_cnt  <= '0;
      end
      if (w_state_nxt == ST_TRIG) begin
        r_trig_cnt <= r_trig_cnt + 1'b1;
        r_hit_seen <= 1'b0;
      end
      if ((r_state == ST_WINDOW) && Chn_trig && !r_hit_seen) begin
        r_hit_seen <= 1'b1;
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end
      if ((w_state_nxt == ST_OUT) && (r_state != ST_OUT)) r_data_out <= w_word;
      if ((r_state == ST_NEXT) && (w_state_nxt == ST_LOAD))
        r_dac_code <= w_next_sum[DAC_WIDTH-1:0];
    end
  end

  assign Dac_code   = r_dac_code;
  assign Dac_load   = r_dac_load;
  assign Rst_cntb   = r_rst_cntb;
  assign Trig_en    = r_trig_en;
  assign Raz_en     = r_raz_en;
  assign Data_out   = r_data_out;
  assign Data_valid = r_data_valid;
  assign Busy       = r_busy;
  assign Done       = r_done;
`ifdef SCURVE_FORCE_RAZ_EN
  assign Force_raz  = r_force_raz;
`endif

endmodule

// File: tb/tb_scurve_seq_ctrl.sv
// tb_scurve_seq_ctrl: table of scan configurations plus hand-written sequences for
// backpressure, Stop, Start with Trig_num=0, and asynchronous reset mid-window.
module tb_scurve_seq_ctrl;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0, Stop = 1'b0;
  logic [9:0]  Dac_start = '0, Dac_stop = '0;
  logic [3:0]  Dac_step = '0;
  logic [15:0] Trig_num = '0;
  logic        Chn_trig = 1'b0, Dac_load_done = 1'b0, Data_ready = 1'b1;
  logic [9:0]  Dac_code;
  logic        Dac_load, Rst_cntb, Trig_en, Raz_en, Data_valid, Busy, Done;
  logic [31:0] Data_out;

  scurve_seq_ctrl dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Stop(Stop),
    .Dac_start(Dac_start), .Dac_stop(Dac_stop), .Dac_step(Dac_step), .Trig_num(Trig_num),
    .Chn_trig(Chn_trig), .Dac_load_done(Dac_load_done), .Data_ready(Data_ready),
    .Dac_code(Dac_code), .Dac_load(Dac_load), .Rst_cntb(Rst_cntb), .Trig_en(Trig_en),
    .Raz_en(Raz_en), .Data_out(Data_out), .Data_valid(Data_valid), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int chn_mode = 0, chn_k = 0;   // 0 never, 1 held high, 2 hit on first k triggers of each step

  // monitor state (written only by the monitor process)
  int n_trig = 0, n_raz = 0, n_done = 0, n_load = 0, n_words = 0;
  int t_trig = 0, t_raz = 0, bad_tr = 0, bad_gap = 0;
  bit have_trig = 0, have_raz = 0;
  logic [31:0] words [0:63];

  typedef struct {
    int start; int stop; int step; int tnum; int mode; int k;
    int nwords; int hits; int last; int trigs;
  } vec_t;
  vec_t vecs [0:4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // slow-control model: Dac_load_done three cycles after each Dac_load
  initial begin
    int ld_wait;
    ld_wait = 0;
    forever begin
      @(posedge Clk); #2;
      Dac_load_done = 1'b0;
      if (ld_wait > 0) begin
        ld_wait--;
        if (ld_wait == 0) Dac_load_done = 1'b1;
      end
      if (Dac_load) ld_wait = 3;
    end
  end

  // channel model: a 3-cycle Chn_trig burst inside the window of qualifying triggers
  initial begin
    int trig_idx, hold;
    bit arm;
    trig_idx = 0; hold = 0; arm = 0;
    forever begin
      @(posedge Clk); #2;
      if (Rst_cntb) trig_idx = 0;
      Chn_trig = (chn_mode == 1);
      if (hold != 0) begin Chn_trig = 1'b1; hold--; end
      if (arm) begin arm = 0; Chn_trig = 1'b1; hold = 2; end
      if (Trig_en) begin
        if (chn_mode == 2 && Trig_num != 0 && (trig_idx % int'(Trig_num)) < chn_k) arm = 1;
        trig_idx++;
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (Trig_en) begin n_trig++; t_trig = cyc; have_trig = 1; end
    if (Raz_en) begin
      n_raz++;
      if (have_trig && (cyc - t_trig) != 9) bad_tr++;
      if (have_raz && (cyc - t_raz) < 49) bad_gap++;
      t_raz = cyc; have_raz = 1;
    end
    if (Done) n_done++;
    if (Dac_load) n_load++;
    if (Data_valid && Data_ready) begin
      if (n_words < 64) words[n_words] = Data_out;
      n_words++;
    end
  end

  task automatic pulse_start();
    @(posedge Clk); #1 Start = 1'b1;
    @(posedge Clk); #1 Start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got;
    got = 0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge Clk);
      if (Done) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: Done not seen within %0d cycles", name, budget);
    end
    @(posedge Clk); #1;
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int tn);
    Dac_start = 10'(s); Dac_stop = 10'(e); Dac_step = 4'(st); Trig_num = 16'(tn);
  endtask

  initial begin
    int b_trig, b_raz, b_done, b_load, b_words, eff, ld_seen;
    bit seen;
    logic [31:0] exp_w;
    int bp_bad;

    vecs[0] = '{start:100,  stop:102,  step:1, tnum:4, mode:2, k:3, nwords:3, hits:3, last:102,  trigs:12};
    vecs[1] = '{start:1020, stop:1023, step:5, tnum:1, mode:0, k:0, nwords:1, hits:0, last:1020, trigs:1};
    vecs[2] = '{start:10,   stop:13,   step:0, tnum:1, mode:1, k:0, nwords:4, hits:1, last:13,   trigs:4};
    vecs[3] = '{start:50,   stop:40,   step:1, tnum:2, mode:2, k:1, nwords:1, hits:1, last:50,   trigs:2};
    vecs[4] = '{start:200,  stop:210,  step:4, tnum:1, mode:2, k:1, nwords:3, hits:1, last:208,  trigs:3};

    repeat (3) @(negedge Clk);
    check("reset_outputs", {Dac_code, Dac_load, Rst_cntb, Trig_en, Raz_en, Data_out, Data_valid, Busy, Done}, '0);
    @(posedge Clk); #1 reset_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      @(posedge Clk); #1;
      set_cfg(vecs[v].start, vecs[v].stop, vecs[v].step, vecs[v].tnum);
      chn_mode = vecs[v].mode; chn_k = vecs[v].k;
      b_trig = n_trig; b_raz = n_raz; b_done = n_done; b_words = n_words;
      pulse_start();
      wait_done($sformatf("vec%0d", v), 20000);
      check($sformatf("vec%0d_nwords", v), 64'(n_words - b_words), 64'(vecs[v].nwords));
      eff = (vecs[v].step == 0) ? 1 : vecs[v].step;
      for (int i = 0; i < vecs[v].nwords && (b_words + i) < 64; i++) begin
        exp_w = (32'(vecs[v].start + i * eff) << 16) | 32'(vecs[v].hits);
        check($sformatf("vec%0d_word%0d", v, i), 64'(words[b_words + i]), 64'(exp_w));
      end
      check($sformatf("vec%0d_trig_en", v), 64'(n_trig - b_trig), 64'(vecs[v].trigs));
      check($sformatf("vec%0d_raz_en", v), 64'(n_raz - b_raz), 64'(vecs[v].trigs));
      check($sformatf("vec%0d_done", v), 64'(n_done - b_done), 64'd1);
      check($sformatf("vec%0d_dac_code", v), 64'(Dac_code), 64'(vecs[v].last));
      check($sformatf("vec%0d_busy_after", v), 64'(Busy), 64'd0);
    end

    // backpressure: word held stable while Data_ready is low
    @(posedge Clk); #1;
    set_cfg(300, 300, 1, 2); chn_mode = 1; Data_ready = 1'b0;
    b_words = n_words;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge Clk);
      if (Data_valid) seen = 1;
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    bp_bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge Clk);
      if (!Data_valid || Data_out !== 32'h012C0002) bp_bad++;
    end
    check("bp_hold_cycles_bad", 64'(bp_bad), 64'd0);
    check("bp_word", 64'(Data_out), 64'h012C0002);
    @(posedge Clk); #1 Data_ready = 1'b1;
    wait_done("bp", 2000);
    check("bp_nwords", 64'(n_words - b_words), 64'd1);

    // Stop three cycles into the second SETTLE
    @(posedge Clk); #1;
    set_cfg(100, 105, 1, 1); chn_mode = 0;
    b_words = n_words; b_done = n_done;
    pulse_start();
    ld_seen = 0;
    for (int k = 0; k < 5000 && ld_seen < 2; k++) begin
      @(negedge Clk);
      if (Dac_load_done) ld_seen++;
    end
    check("stop_second_load", 64'(ld_seen), 64'd2);
    repeat (3) @(posedge Clk);
    #1 Stop = 1'b1;
    b_trig = n_trig; b_load = n_load;
    @(posedge Clk); #1 Stop = 1'b0;
    @(negedge Clk);
    check("stop_outputs", {Busy, Trig_en, Raz_en, Dac_load, Data_valid, Done}, '0);
    repeat (700) @(posedge Clk);
    #1;
    check("stop_no_trig", 64'(n_trig - b_trig), 64'd0);
    check("stop_no_load", 64'(n_load - b_load), 64'd0);
    check("stop_no_done", 64'(n_done - b_done), 64'd0);
    check("stop_nwords", 64'(n_words - b_words), 64'd1);
    if (b_words < 64) check("stop_word", 64'(words[b_words]), 64'h00640000);

    // Start with Trig_num == 0, then Start and Stop together
    set_cfg(5, 9, 1, 0);
    b_load = n_load;
    pulse_start();
    repeat (5) @(negedge Clk);
    check("tnum0_busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    set_cfg(5, 9, 1, 1); Start = 1'b1; Stop = 1'b1;
    @(posedge Clk); #1 Start = 1'b0; Stop = 1'b0;
    repeat (5) @(negedge Clk);
    check("start_stop_busy", 64'(Busy), 64'd0);
    @(posedge Clk); #1;
    check("idle_no_load", 64'(n_load - b_load), 64'd0);

    // asynchronous reset in the first WINDOW cycle
    set_cfg(400, 410, 1, 2); chn_mode = 1;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge Clk);
      if (Trig_en) seen = 1;
    end
    check("rst_trig_seen", 64'(seen), 64'd1);
    check("rst_dout_nonzero_before", 64'(Data_out != 32'h0), 64'd1);
    @(posedge Clk); #1 reset_n = 1'b0;
    #1;
    check("rst_mid_window", {Dac_code, Dac_load, Rst_cntb, Trig_en, Raz_en, Data_out, Data_valid, Busy, Done}, '0);
    repeat (2) @(posedge Clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_release_busy", 64'(Busy), 64'd0);

    @(posedge Clk); #1;
    check("trig_to_raz_bad", 64'(bad_tr), 64'd0);
    check("raz_gap_bad", 64'(bad_gap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scurve_seq_ctrl.md
Name: scurve_seq_ctrl

Overview:
Sequencer for the ASIC S-curve threshold scan. It drives the trigger/RAZ/BCID-reset generator through its control inputs: rst_cntb, Raz_en and Trig_en. For each DAC threshold step it does the following, then emits one result word per step to the readout FIFO:
- loads the threshold through a slow-control handshake;
- waits for settling;
- fires Trig_num external triggers;
- counts channel hits per trigger;
- issues a RAZ after every trigger.

Parameters:
DAC_WIDTH, 10, threshold DAC code width
CNT_WIDTH, 16, per-step hit/trigger counter width (DAC_WIDTH+CNT_WIDTH <= 32)
SETTLE_CYCLES, 400, Clk cycles (10 us at 40 MHz) between DAC load done and first trigger
WINDOW_CYCLES, 8, Clk cycles after Trig_en during which Chn_trig is sampled
RAZ_GAP, 48, Clk cycles Raz_en held low after each RAZ pulse (>= 42, covers 1 us RAZ mode)
BCID_WAIT, 48, Clk cycles after rst_cntb pulse before first DAC load (> 40-cycle reset width)

Ports:
Clk  in  1  system clock, 40 MHz
reset_n  in  1  asynchronous active-low reset
Start  in  1  one-cycle pulse, begin scan
Stop  in  1  level/pulse, abort scan
Dac_start  in  DAC_WIDTH  first threshold code
Dac_stop  in  DAC_WIDTH  last threshold code (inclusive)
Dac_step  in  4  code increment; 0 treated as 1
Trig_num  in  CNT_WIDTH  triggers per step
Chn_trig  in  1  channel trigger output, already synchronised to Clk
Dac_load_done  in  1  slow-control load complete (one-cycle pulse)
Data_ready  in  1  FIFO can accept
Dac_code  out  DAC_WIDTH  current threshold
Dac_load  out  1  one-cycle load request
Rst_cntb  out  1  one-cycle pulse to generator rst_cntb
Trig_en  out  1  one-cycle trigger pulse
Raz_en  out  1  one-cycle RAZ pulse (generator edge-detects)
Data_out  out  32  {zero pad, Dac_code, hit_cnt}, hit_cnt in LSBs
Data_valid  out  1  result word valid
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle pulse at normal scan completion

Behaviour:
- Reset: every output is 0; Dac_code = 0; FSM in IDLE; all counters 0.
- Clocking: Clk only; all outputs are registered.
- IDLE:
  - Start with Trig_num != 0 latches Dac_start/Dac_stop/Dac_step/Trig_num, sets Dac_code = Dac_start, and goes to BCID.
  - Start with Trig_num == 0 is ignored.
- BCID: Rst_cntb = 1 for the entry cycle only; wait BCID_WAIT cycles, then go to LOAD.
- LOAD: Dac_load = 1 for the entry cycle; wait for Dac_load_done (no timeout); clear hit_cnt and trig_cnt; go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to TRIG.
- TRIG: Trig_en = 1 for exactly one cycle; trig_cnt++; go to WINDOW.
- WINDOW (WINDOW_CYCLES cycles): if Chn_trig is high on any cycle, hit_cnt increments once for this trigger. hit_cnt saturates at all-ones.
- RAZ: Raz_en = 1 for one cycle, then low for RAZ_GAP cycles. Then:
  - if trig_cnt == Trig_num, go to OUT;
  - otherwise go to TRIG.
- OUT: Data_valid is held with a stable Data_out until the cycle Data_ready = 1 (transfer on valid & ready). Then go to NEXT.
- NEXT: next = Dac_code + step, computed at DAC_WIDTH+1 bits.
  - If next > Dac_stop, or the carry bit is set, or Dac_start > Dac_stop: go to DONE.
  - Otherwise Dac_code = next and go to LOAD (no BCID repeat).
- DONE: Done = 1 for one cycle, then go to IDLE. Dac_code keeps its last value.
- Start while Busy is ignored.
- Stop, in any non-IDLE state:
  - next cycle goes to IDLE; Busy, Trig_en, Raz_en, Dac_load, Data_valid drop to 0;
  - no Done pulse; the pending result word is discarded.
- Start and Stop in the same cycle: Stop wins, and the FSM stays in IDLE.
- Asynchronous reset mid-scan: returns immediately to reset values.

Optional Feature:
SCURVE_FORCE_RAZ_EN: when defined, adds output Force_raz (1 bit). It is high throughout LOAD and SETTLE so the channels are held in reset while the threshold moves, and low otherwise; its reset value is 0. When undefined, the port is absent and the timing is otherwise identical.

Decomposition:
- Package scurve_pkg:
  - FSM state enum (IDLE, BCID, LOAD, SETTLE, TRIG, WINDOW, RAZ, OUT, NEXT, DONE);
  - DAC_WIDTH/CNT_WIDTH defaults;
  - Data_out field offsets;
  - 40 MHz timing constants.
- One sub-module, scurve_step_timer: a loadable down-counter with a terminal-count pulse. It is shared by BCID_WAIT, SETTLE, WINDOW and RAZ_GAP.

Test Plan:
1. Dac_start=100, Dac_stop=102, Dac_step=1, Trig_num=4, Chn_trig pulsed in the window of triggers 1–3 only, Data_ready=1 -> words 0x00640003, 0x00650003, 0x00660003; exactly 12 Trig_en and 12 Raz_en pulses; one Done.
2. Dac_start=1020, Dac_stop=1023, Dac_step=5, Trig_num=1 -> single word with Dac_code=1020 (carry terminates the scan); Done; Dac_code stays 1020.
3. Trig_num=2; Chn_trig held high for the whole scan; Data_ready=0 for 100 cycles in OUT -> Data_valid and Data_out stable throughout; word = {Dac, 16'd2}.
4. Stop asserted 3 cycles into the second SETTLE -> Busy=0 on the next cycle, no further Trig_en/Dac_load, no Done, only one word emitted.
5. Check spacing between consecutive Raz_en rising edges: >= RAZ_GAP+1 = 49 cycles. Check Trig_en to the next Raz_en: exactly WINDOW_CYCLES+1 = 9 cycles.
6. Start with Trig_num=0 -> stays IDLE, Busy=0. reset_n low mid-WINDOW -> all outputs 0 immediately.
